// File: rtl/square_stage_pipe.sv
// square_stage_pipe: II=1 square/saturate/pass/negate stage between ping-pong buffers B and D
module square_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int N      = 5
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ADDR_W:0]   len,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] B_address0,
    output logic              B_ce0,
    input  logic [DATA_W-1:0] B_q0,
    output logic [ADDR_W-1:0] D_address0,
    output logic              D_ce0,
    output logic              D_we0,
    output logic [DATA_W-1:0] D_d0
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    localparam logic [ADDR_W:0]   N_L     = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   ONE     = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    state_t                     state, state_nx;
    logic                       held_done, accept, ovf;
    logic [ADDR_W:0]            k, l_q;
    logic [1:0]                 mode_q, drain_cnt;
    logic                       v1, v2, v3;
    logic [ADDR_W-1:0]          a1, a2, a3;
    logic signed [DATA_W-1:0]   q2;
    logic [DATA_W-1:0]          r3, res;
    logic signed [2*DATA_W-1:0] qx, prod;
    assign accept = state == IDLE && ap_start && !held_done;
    // state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nx;
    end
    // next state: RUN issues one read per cycle, DRAIN flushes the 3 pipeline stages
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = (len == '0) ? DRAIN : RUN;
            RUN:   if (k + ONE == l_q) state_nx = DRAIN;
            DRAIN: if (drain_cnt == 2'd2) state_nx = FIN;
            FIN:   state_nx = IDLE;
        endcase
    end
    // per-call context: read index, clamped length, mode, drain count, held done (continue wins)
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            k         <= '0;
            l_q       <= '0;
            mode_q    <= '0;
            drain_cnt <= '0;
            held_done <= 1'b0;
        end else begin
            if (accept) begin
                k      <= '0;
                l_q    <= len > N_L ? N_L : len;
                mode_q <= mode;
            end else if (state == RUN) begin
                k <= k + ONE;
            end
            drain_cnt <= state == DRAIN ? drain_cnt + 2'd1 : 2'd0;
            held_done <= ap_continue ? 1'b0 : (state == FIN) ? 1'b1 : held_done;
        end
    end
    // datapath pipeline: stage1 waits on read latency, stage2 captures data, stage3 holds result
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            a1 <= '0;
            a2 <= '0;
            a3 <= '0;
            q2 <= '0;
            r3 <= '0;
        end else begin
            v1 <= state == RUN;
            a1 <= k[ADDR_W-1:0];
            v2 <= v1;
            a2 <= a1;
            q2 <= B_q0;
            v3 <= v2;
            a3 <= a2;
            r3 <= res;
        end
    end
    // element arithmetic; a square is never negative, so any set bit at or above DATA_W-1 overflows
    always_comb begin
        qx   = (2*DATA_W)'(q2);
        prod = qx * qx;
        ovf  = |prod[2*DATA_W-1:DATA_W-1];
        res  = mode_q == 2'b00 ? prod[DATA_W-1:0] :
               mode_q == 2'b01 ? (ovf ? SAT_MAX : prod[DATA_W-1:0]) :
               mode_q == 2'b10 ? q2 : -q2;
    end
    // handshake and memory port outputs, forced to zero outside their strobes
    always_comb begin
        ap_done    = state == FIN || held_done;
        ap_ready   = state == FIN;
        ap_idle    = state == IDLE && !ap_start;
        B_ce0      = state == RUN;
        B_address0 = state == RUN ? k[ADDR_W-1:0] : '0;
        D_ce0      = v3;
        D_we0      = v3;
        D_address0 = v3 ? a3 : '0;
        D_d0       = v3 ? r3 : '0;
    end
endmodule

// File: tb/tb_square_stage_pipe.sv
// tb_square_stage_pipe: randomized directed bench with a behavioural model of the square stage
module tb_square_stage_pipe;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int NN = 5;
    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_continue = 1'b0;
    logic          ap_done, ap_idle, ap_ready;
    logic [AW:0]   len = '0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] B_address0, D_address0;
    logic          B_ce0, D_ce0, D_we0;
    logic [DW-1:0] B_q0, D_d0;
    logic [DW-1:0] bmem [8];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    square_stage_pipe #(.DATA_W(DW), .ADDR_W(AW), .N(NN)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .len(len), .mode(mode),
        .B_address0(B_address0), .B_ce0(B_ce0), .B_q0(B_q0),
        .D_address0(D_address0), .D_ce0(D_ce0), .D_we0(D_we0), .D_d0(D_d0)
    );

    always #5 ap_clk = ~ap_clk;

    // buffer B: one-cycle read latency, garbage when not enabled
    always @(posedge ap_clk) begin
        cyc  <= cyc + 1;
        B_q0 <= B_ce0 ? bmem[B_address0] : $urandom();
    end

    function automatic logic [31:0] ref_f(input logic [1:0] m, input logic [31:0] x);
        longint sx, p;
        sx = longint'($signed(x));
        p  = sx * sx;
        if (m == 2'd0) return 32'(p);
        if (m == 2'd1) return p > 64'sd2147483647 ? 32'h7fffffff : 32'(p);
        if (m == 2'd2) return x;
        return 32'(-sx);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // issue one call and check every read, write and the done cycle against the model
    task automatic run_call(input int l, input logic [1:0] md, input bit cont);
        int s, lc, nr, nw, t;
        bit seen;
        lc = l > NN ? NN : l;
        nr = 0;
        nw = 0;
        seen = 0;
        @(negedge ap_clk);
        ap_continue = 1'b0;
        chk("idle_before", ap_idle, 1);
        chk("done_clear", ap_done, 0);
        ap_start = 1'b1;
        len = l[AW:0];
        mode = md;
        s = cyc;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge ap_clk);
            if (i == 0) begin
                ap_start = 1'b0;
                len = 4'($urandom);
                mode = 2'($urandom);
            end
            t = cyc - s;
            if (B_ce0) begin
                chk("rd_addr", B_address0, nr);
                chk("rd_cyc", t, nr + 1);
                nr++;
            end
            if (D_ce0 || D_we0) begin
                chk("wr_strobes", {D_ce0, D_we0}, 2'b11);
                chk("wr_addr", D_address0, nw);
                chk("wr_data", D_d0, ref_f(md, bmem[nw & 7]));
                chk("wr_cyc", t, nw + 4);
                nw++;
            end
            if (ap_done) begin
                seen = 1;
                chk("done_cyc", t, lc + 4);
                chk("ready_fin", ap_ready, 1);
                if (cont) ap_continue = 1'b1;
            end
        end
        chk("done_seen", seen, 1);
        chk("n_reads", nr, lc);
        chk("n_writes", nw, lc);
    endtask

    task automatic after_fin(input bit cont);
        @(negedge ap_clk);
        chk("ready_pulse", ap_ready, 0);
        chk("held_done", ap_done, !cont);
        ap_continue = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) bmem[i] = $urandom();
        #1;
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_bce", B_ce0, 0);
        chk("rst_dce", D_ce0, 0);
        chk("rst_dwe", D_we0, 0);
        chk("rst_idle", ap_idle, 1);
        ap_start = 1'b1;
        #1;
        chk("rst_idle_start", ap_idle, 0);
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        // basic squares
        bmem[0] = 1; bmem[1] = -2; bmem[2] = 3; bmem[3] = -4; bmem[4] = 5;
        run_call(5, 2'b00, 1);
        after_fin(1);
        // saturation versus wrap
        bmem[0] = 70000;
        run_call(1, 2'b01, 1);
        after_fin(1);
        run_call(1, 2'b00, 1);
        after_fin(1);
        // pass-through and negate, including the most negative value
        bmem[0] = 32'h80000000; bmem[1] = 7;
        run_call(2, 2'b10, 1);
        after_fin(1);
        run_call(2, 2'b11, 0);
        after_fin(0);
        // done held: new start ignored until continue
        ap_start = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            chk("hold_done", ap_done, 1);
            chk("hold_no_read", B_ce0, 0);
            chk("hold_ready", ap_ready, 0);
        end
        ap_start = 1'b0;
        ap_continue = 1'b1;
        // boundaries: empty call, over-long call, then back-to-back
        run_call(0, 2'($urandom), 1);
        after_fin(1);
        for (int i = 0; i < 8; i++) bmem[i] = $urandom();
        run_call(7, 2'($urandom), 1);
        run_call(5, 2'($urandom), 1);
        after_fin(1);
        // random calls, mixing back-to-back and spaced starts
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) bmem[i] = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom();
            run_call($urandom_range(0, 9), 2'($urandom), 1);
            if ($urandom_range(0, 1) == 1) after_fin(1);
        end
        after_fin(1);
        // reset in the middle of a call
        @(negedge ap_clk);
        ap_start = 1'b1;
        len = 4'd5;
        mode = 2'b00;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (4) @(negedge ap_clk);
        chk("pre_rst_read", B_ce0, 1);
        chk("pre_rst_write", D_ce0, 1);
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_bce", B_ce0, 0);
        chk("mid_rst_dce", D_ce0, 0);
        chk("mid_rst_dwe", D_we0, 0);
        chk("mid_rst_done", ap_done, 0);
        chk("mid_rst_ready", ap_ready, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (8) begin
            @(negedge ap_clk);
            chk("post_rst_dce", D_ce0, 0);
            chk("post_rst_done", ap_done, 0);
        end
        run_call(5, 2'b00, 1);
        after_fin(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
